// File: rtl/btb_update_scheduler.sv
// btb_update_scheduler
// Arbitrates the single-ported BTB array between IF-stage lookups (priority)
// and EX-stage branch-resolution updates. Updates are buffered in a small
// FIFO and retired as a PROBE (lookup of the branch PC) followed by a WRITE
// (overwrite on hit, round-robin allocate on miss). A starvation counter
// forces a retirement after STARVE_MAX consecutive fetch-busy IDLE cycles.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_req/fetch_pc    IF lookup request and PC
//   fetch_stall           lookup not serviced this cycle
//   upd_valid/upd_ready   update handshake; upd_pc/upd_target/upd_taken payload
//   btb_op                00 idle, 01 lookup, 10 overwrite, 11 allocate
//   btb_pc/btb_idx        lookup PC / write index
//   btb_wdata             {pc, target, taken}
//   btb_hit/btb_hit_idx   combinational array lookup result
//   q_count               FIFO occupancy
//   alloc_ptr             next round-robin allocation slot
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | port serves fetch lookups
// PROBE | look up FIFO head PC, capture hit/hit_idx
// WRITE | overwrite (hit) or allocate (miss) the head entry, dequeue it

module btb_update_scheduler #(
   parameter int ENTRIES_LOG2 = 3,
   parameter int QDEPTH       = 4,
   parameter int STARVE_MAX   = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      fetch_req,
   input  logic [31:0]               fetch_pc,
   output logic                      fetch_stall,
   input  logic                      upd_valid,
   input  logic [31:0]               upd_pc,
   input  logic [31:0]               upd_target,
   input  logic                      upd_taken,
   output logic                      upd_ready,
   output logic [1:0]                btb_op,
   output logic [31:0]               btb_pc,
   output logic [ENTRIES_LOG2-1:0]   btb_idx,
   output logic [64:0]               btb_wdata,
   input  logic                      btb_hit,
   input  logic [ENTRIES_LOG2-1:0]   btb_hit_idx,
   output logic [$clog2(QDEPTH):0]   q_count,
   output logic [ENTRIES_LOG2-1:0]   alloc_ptr
);

   localparam int QW = $clog2(QDEPTH);
   localparam int CW = QW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      PROBE = 2'b01,
      WRITE = 2'b10
   } state_t;

   state_t state, state_next;

   logic [31:0] pc_mem  [QDEPTH];
   logic [31:0] tgt_mem [QDEPTH];
   logic        tkn_mem [QDEPTH];

   logic [QW-1:0]           head, tail;
   logic [SW-1:0]           starve;
   logic                    hit_r;
   logic [ENTRIES_LOG2-1:0] hit_idx_r;
   logic                    enq, deq;
   logic                    q_pending;

   assign upd_ready = (q_count < QDEPTH_C);
   assign enq       = upd_valid && upd_ready;
   assign deq       = (state == WRITE);
   // An update accepted this cycle is readable from storage next cycle,
   // so it already counts as pending for the transition decision.
   assign q_pending = (q_count != '0) || enq;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (q_pending && (!fetch_req || starve == STARVE_C)) state_next = PROBE;
         PROBE: state_next = WRITE;
         WRITE: begin
            if (((q_count > CW'(1)) || enq) && !fetch_req) state_next = PROBE;
            else                                            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      btb_op    = 2'b00;
      btb_pc    = fetch_pc;
      btb_idx   = '0;
      btb_wdata = '0;
      case (state)
         IDLE:  btb_op = fetch_req ? 2'b01 : 2'b00;
         PROBE: begin
            btb_op = 2'b01;
            btb_pc = pc_mem[head];
         end
         WRITE: begin
            btb_op    = hit_r ? 2'b10 : 2'b11;
            btb_idx   = hit_r ? hit_idx_r : alloc_ptr;
            btb_wdata = {pc_mem[head], tgt_mem[head], tkn_mem[head]};
         end
         default: btb_op = 2'b00;
      endcase
   end

   assign fetch_stall = fetch_req && (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         head      <= '0;
         tail      <= '0;
         q_count   <= '0;
         alloc_ptr <= '0;
         starve    <= '0;
         hit_r     <= 1'b0;
         hit_idx_r <= '0;
      end else begin
         state <= state_next;
         if (enq) tail <= tail + 1'b1;
         if (deq) head <= head + 1'b1;
         case ({enq, deq})
            2'b10:   q_count <= q_count + 1'b1;
            2'b01:   q_count <= q_count - 1'b1;
            default: q_count <= q_count;
         endcase
         if (state == PROBE) begin
            hit_r     <= btb_hit;
            hit_idx_r <= btb_hit_idx;
         end
         if (state == WRITE && !hit_r) alloc_ptr <= alloc_ptr + 1'b1;
         if (q_count == '0)
            starve <= '0;
         else if (state_next == PROBE)
            starve <= '0;
         else if (state == IDLE && fetch_req && starve != STARVE_C)
            starve <= starve + 1'b1;
      end
   end

   // Payload storage needs no reset: occupancy is tracked by q_count alone.
   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem[tail]  <= upd_pc;
         tgt_mem[tail] <= upd_target;
         tkn_mem[tail] <= upd_taken;
      end
   end

endmodule

// File: tb/tb_btb_update_scheduler.sv
module tb_btb_update_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        fetch_stall;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        upd_ready;
   logic [1:0]  btb_op;
   logic [31:0] btb_pc;
   logic [2:0]  btb_idx;
   logic [64:0] btb_wdata;
   logic        btb_hit;
   logic [2:0]  btb_hit_idx;
   logic [2:0]  q_count;
   logic [2:0]  alloc_ptr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   btb_update_scheduler #(.ENTRIES_LOG2(3), .QDEPTH(4), .STARVE_MAX(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken), .upd_ready(upd_ready),
      .btb_op(btb_op), .btb_pc(btb_pc), .btb_idx(btb_idx), .btb_wdata(btb_wdata),
      .btb_hit(btb_hit), .btb_hit_idx(btb_hit_idx),
      .q_count(q_count), .alloc_ptr(alloc_ptr)
   );

   // Behavioural BTB array: 8 entries, combinational lookup, write on posedge.
   logic [7:0]  m_v;
   logic [31:0] m_pc [8];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_v <= '0;
      else if (btb_op[1]) begin
         m_v[btb_idx]  <= 1'b1;
         m_pc[btb_idx] <= btb_wdata[64:33];
      end
   end

   always_comb begin
      btb_hit     = 1'b0;
      btb_hit_idx = '0;
      if (btb_op == 2'b01)
         for (int i = 0; i < 8; i++)
            if (m_v[i] && m_pc[i] == btb_pc) begin
               btb_hit     = 1'b1;
               btb_hit_idx = 3'(i);
            end
   end

   task automatic idle_inputs();
      fetch_req = 1'b0; fetch_pc = '0; upd_valid = 1'b0;
      upd_pc = '0; upd_target = '0; upd_taken = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk); idle_inputs(); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle_inputs();
      fetch_req = 1'b1; fetch_pc = 32'h40;
      #1;
      checks++; if (btb_op !== 2'b01) begin errors++; $display("FAIL reset_op got=%b exp=01", btb_op); end
      checks++; if (btb_pc !== 32'h40) begin errors++; $display("FAIL reset_pc got=%h exp=40", btb_pc); end
      checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", fetch_stall); end
      checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", upd_ready); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_qcount got=%0d exp=0", q_count); end
      checks++; if (alloc_ptr !== 3'd0) begin errors++; $display("FAIL reset_alloc got=%0d exp=0", alloc_ptr); end
      checks++; if (btb_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", btb_idx); end
      checks++; if (btb_wdata !== 65'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", btb_wdata); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; idle_inputs();
   endtask

   // One update with fetch idle: N accept, N+1 PROBE, N+2 WRITE, N+3 idle.
   task automatic test_update(input logic tk, input logic [1:0] exp_op, input logic [2:0] exp_idx,
                              input logic [2:0] exp_alloc, input string tag);
      @(negedge clk);
      fetch_req = 1'b0; upd_valid = 1'b1; upd_pc = 32'h100; upd_target = 32'h200; upd_taken = tk;
      #1;
      checks++; if (btb_op !== 2'b00) begin errors++; $display("FAIL %s_n_op got=%b exp=00", tag, btb_op); end
      @(negedge clk); upd_valid = 1'b0; #1;
      checks++; if (btb_op !== 2'b01) begin errors++; $display("FAIL %s_probe_op got=%b exp=01", tag, btb_op); end
      checks++; if (btb_pc !== 32'h100) begin errors++; $display("FAIL %s_probe_pc got=%h exp=100", tag, btb_pc); end
      @(negedge clk); #1;
      checks++; if (btb_op !== exp_op) begin errors++; $display("FAIL %s_write_op got=%b exp=%b", tag, btb_op, exp_op); end
      checks++; if (btb_idx !== exp_idx) begin errors++; $display("FAIL %s_write_idx got=%0d exp=%0d", tag, btb_idx, exp_idx); end
      checks++;
      if (btb_wdata !== {32'h100, 32'h200, tk}) begin
         errors++; $display("FAIL %s_write_wdata got=%h exp=%h", tag, btb_wdata, {32'h100, 32'h200, tk});
      end
      @(negedge clk); #1;
      checks++; if (btb_op !== 2'b00) begin errors++; $display("FAIL %s_after_op got=%b exp=00", tag, btb_op); end
      checks++; if (alloc_ptr !== exp_alloc) begin errors++; $display("FAIL %s_alloc got=%0d exp=%0d", tag, alloc_ptr, exp_alloc); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL %s_qcount got=%0d exp=0", tag, q_count); end
   endtask

   // Update queued under continuous fetch: 4 serviced IDLE cycles while the
   // starve counter climbs 0..3, then PROBE and WRITE stall fetch.
   task automatic test_starvation();
      @(negedge clk);
      fetch_req = 1'b1; fetch_pc = 32'h300;
      upd_valid = 1'b1; upd_pc = 32'h400; upd_target = 32'h500; upd_taken = 1'b1;
      #1;
      checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL starve_enq_stall got=%b exp=0", fetch_stall); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); upd_valid = 1'b0; #1;
         checks++; if (fetch_stall !== 1'b0 || btb_op !== 2'b01) begin
            errors++; $display("FAIL starve_service%0d stall=%b op=%b exp stall=0 op=01", k, fetch_stall, btb_op);
         end
      end
      @(negedge clk); #1;
      checks++; if (fetch_stall !== 1'b1 || btb_pc !== 32'h400) begin
         errors++; $display("FAIL starve_probe stall=%b pc=%h exp stall=1 pc=400", fetch_stall, btb_pc);
      end
      @(negedge clk); #1;
      checks++; if (fetch_stall !== 1'b1) begin errors++; $display("FAIL starve_write_stall got=%b exp=1", fetch_stall); end
      checks++; if (btb_op !== 2'b11 || btb_idx !== 3'd1) begin
         errors++; $display("FAIL starve_write op=%b idx=%0d exp op=11 idx=1", btb_op, btb_idx);
      end
      @(negedge clk); #1;
      checks++; if (fetch_stall !== 1'b0 || btb_op !== 2'b01) begin
         errors++; $display("FAIL starve_resume stall=%b op=%b exp stall=0 op=01", fetch_stall, btb_op);
      end
      checks++; if (alloc_ptr !== 3'd2) begin errors++; $display("FAIL starve_alloc got=%0d exp=2", alloc_ptr); end
   endtask

   // Nine allocating updates back to back with fetch idle: indices 0..7,0.
   task automatic test_back_to_back();
      int sent = 0;
      int writes = 0;
      logic [2:0] exp_idx = 3'd0;
      logic full_seen = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 60 && writes < 9; cyc++) begin
         @(negedge clk);
         fetch_req = 1'b0;
         upd_valid = (sent < 9);
         upd_pc = 32'h1000 + 32'(sent) * 4; upd_target = 32'h8000 + 32'(sent); upd_taken = 1'b1;
         #1;
         checks++; if (q_count > 3'd4) begin errors++; $display("FAIL b2b_qcount got=%0d exp<=4", q_count); end
         checks++; if (upd_ready !== (q_count != 3'd4)) begin
            errors++; $display("FAIL b2b_ready got=%b at q_count=%0d", upd_ready, q_count);
         end
         if (q_count == 3'd4) full_seen = 1'b1;
         if (btb_op == 2'b10) begin
            errors++; $display("FAIL b2b_unexpected_overwrite op=10 exp=11");
         end
         if (btb_op == 2'b11) begin
            checks++; if (btb_idx !== exp_idx) begin
               errors++; $display("FAIL b2b_idx%0d got=%0d exp=%0d", writes, btb_idx, exp_idx);
            end
            exp_idx = exp_idx + 3'd1;
            writes++;
         end
         if (upd_valid && upd_ready) sent++;
      end
      @(negedge clk); upd_valid = 1'b0;
      checks++; if (writes != 9) begin errors++; $display("FAIL b2b_writes got=%0d exp=9", writes); end
      checks++; if (!full_seen) begin errors++; $display("FAIL b2b_full got=0 exp=1 (q_count never reached 4)"); end
      checks++; if (alloc_ptr !== 3'd1) begin errors++; $display("FAIL b2b_alloc got=%0d exp=1", alloc_ptr); end
   endtask

   // Four updates queued under fetch; reset asserted in the first WRITE.
   task automatic test_reset_mid_write();
      logic found = 1'b0;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         fetch_req = 1'b1; fetch_pc = 32'h40;
         upd_valid = 1'b1; upd_pc = 32'h2000 + 32'(k) * 4; upd_target = 32'h3000; upd_taken = 1'b0;
      end
      for (int cyc = 0; cyc < 20 && !found; cyc++) begin
         @(negedge clk); upd_valid = 1'b0; #1;
         if (btb_op[1]) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL rstw_timeout no WRITE seen within 20 cycles"); end
      checks++; if (q_count !== 3'd4) begin errors++; $display("FAIL rstw_qcount_pre got=%0d exp=4", q_count); end
      rst_n = 1'b0; fetch_req = 1'b0; #1;
      checks++; if (btb_op !== 2'b00) begin errors++; $display("FAIL rstw_op got=%b exp=00", btb_op); end
      checks++; if (q_count !== 3'd0) begin errors++; $display("FAIL rstw_qcount got=%0d exp=0", q_count); end
      checks++; if (btb_idx !== 3'd0 || btb_wdata !== 65'd0) begin
         errors++; $display("FAIL rstw_write_bus idx=%0d wdata=%h exp 0/0", btb_idx, btb_wdata);
      end
      checks++; if (upd_ready !== 1'b1 || fetch_stall !== 1'b0) begin
         errors++; $display("FAIL rstw_handshake ready=%b stall=%b exp 1/0", upd_ready, fetch_stall);
      end
      @(negedge clk); rst_n = 1'b1; fetch_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #1;
         checks++; if (btb_op !== 2'b01 || fetch_stall !== 1'b0 || q_count !== 3'd0) begin
            errors++; $display("FAIL rstw_after%0d op=%b stall=%b q=%0d exp 01/0/0", k, btb_op, fetch_stall, q_count);
         end
      end
      fetch_req = 1'b0;
      @(negedge clk); #1;
      checks++; if (btb_op !== 2'b00) begin errors++; $display("FAIL rstw_quiet got=%b exp=00", btb_op); end
   endtask

   initial begin
      test_reset();
      test_update(1'b1, 2'b11, 3'd0, 3'd1, "alloc");
      test_update(1'b0, 2'b10, 3'd0, 3'd1, "hit");
      test_starvation();
      test_back_to_back();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
